// File: rtl/pipelined_subtractor.sv
// Segmented ripple-borrow subtractor D = A - B - BI with a valid/ready pipeline.
// Define PSUB_DEBUG_EN to expose per-stage registers and the stall-hold check.
module pipelined_subtractor #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             OutValid,
  input  logic             OutReady
`ifdef PSUB_DEBUG_EN
  ,
  output logic [WIDTH-1:0] D_debug [STAGES],
  output logic [STAGES-1:0] Bw_debug
`endif
);

  localparam int SLICE = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || STAGES < 2) begin : g_bad_cfg
    $error("pipelined_subtractor: WIDTH must be a multiple of STAGES >= 2");
  end

  logic [STAGES-1:0] vld_v;
  logic [STAGES-1:0] brw_v;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  wrd_v [STAGES];

  // Stage words shift right one slice per stage: remaining A bits sit low,
  // finished D slices enter at the top, so the last word is the full D.
  for (genvar g = 0; g < STAGES; g++) begin : st
    localparam int IN_W = WIDTH - g * SLICE;

    logic [WIDTH-1:0] w_src;
    logic [IN_W-1:0]  b_src;
    logic             b_in;
    logic             v_in;
    logic [SLICE:0]   diff;
    logic             vld;
    logic             brw;
    logic [WIDTH-1:0] wrd;

    if (g == 0) begin : g_head
      assign w_src = A;
      assign b_src = B;
      assign b_in  = BI;
      assign v_in  = InValid;
    end else begin : g_body
      assign w_src = wrd_v[g-1];
      assign b_src = st[g-1].g_rem.b_q;
      assign b_in  = brw_v[g-1];
      assign v_in  = vld_v[g-1];
    end

    // A stage may move when it, or anything downstream, has room.
    assign rdy[g] = OutReady | ~(&vld_v[STAGES-1:g]);

    assign diff = {1'b0, w_src[SLICE-1:0]}
                - {1'b0, b_src[SLICE-1:0]}
                - {{SLICE{1'b0}}, b_in};

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        vld <= 1'b0;
        brw <= 1'b0;
        wrd <= '0;
      end else if (rdy[g]) begin
        vld <= v_in;
        if (v_in) begin
          wrd <= {diff[SLICE-1:0], w_src[WIDTH-1:SLICE]};
          brw <= diff[SLICE];
        end
      end
    end

    if (g < STAGES - 1) begin : g_rem
      logic [IN_W-SLICE-1:0] b_q;

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          b_q <= '0;
        end else if (rdy[g] && v_in) begin
          b_q <= b_src[IN_W-1:SLICE];
        end
      end
    end

    assign vld_v[g] = vld;
    assign brw_v[g] = brw;
    assign wrd_v[g] = wrd;
  end

  assign InReady  = rdy[0];
  assign D        = wrd_v[STAGES-1];
  assign BO       = brw_v[STAGES-1];
  assign OutValid = vld_v[STAGES-1];

`ifdef PSUB_DEBUG_EN
  assign D_debug  = wrd_v;
  assign Bw_debug = brw_v;

  a_hold_valid: assert property (
    @(posedge Clock) disable iff (Reset)
    OutValid && !OutReady |=> OutValid
  ) else $error("pipelined_subtractor: OutValid dropped while stalled");
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: scoreboard model, directed corners,
// backpressure, mid-stream reset and adder round-trip with random stimulus.
module tb_pipelined_subtractor;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BI = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b1;
  logic        InReady;
  logic [31:0] D;
  logic        BO;
  logic        OutValid;
`ifdef PSUB_DEBUG_EN
  logic [31:0] D_debug [4];
  logic [3:0]  Bw_debug;
`endif

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int ret_cnt = 0;
  int n, seen, base_acc, base_ret;
  logic done;

  logic [32:0] q [$];
  logic [32:0] out_last = '0;
  logic [32:0] held = '0;
  logic        stalled = 1'b0;
  logic [31:0] exp_d = '0;
  logic        exp_bo = 1'b0;

  pipelined_subtractor #(.WIDTH(32), .STAGES(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .A(A),
    .B(B),
    .BI(BI),
    .InValid(InValid),
    .InReady(InReady),
    .D(D),
    .BO(BO),
    .OutValid(OutValid),
    .OutReady(OutReady)
`ifdef PSUB_DEBUG_EN
    ,
    .D_debug(D_debug),
    .Bw_debug(Bw_debug)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic; bit 32 is the borrow.
  function automatic logic [32:0] sub_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic bi);
    return {1'b0, a} - {1'b0, b} - 33'(bi);
  endfunction

  // Mid-cycle monitor: inputs and OutReady only move just after posedge.
  always @(negedge Clock) begin
    if (Reset) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (InValid && InReady) begin
        q.push_back({exp_bo, exp_d});
        acc_cnt++;
      end
      if (OutValid) begin
        if (stalled) check("stall_hold", {BO, D}, held);
        if (OutReady) begin
          out_last = {BO, D};
          if (q.size() == 0) check("spurious_out", q.size(), 1);
          else check("scoreboard", {BO, D}, q.pop_front());
          ret_cnt++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {BO, D};
        end
      end else begin
        if (stalled) check("valid_drop", OutValid, 1'b1);
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic bi, input logic [31:0] ed,
                      input logic ebo);
    int k;
    A = a;
    B = b;
    BI = bi;
    exp_d = ed;
    exp_bo = ebo;
    InValid = 1'b1;
    k = 0;
    @(negedge Clock);
    while (!InReady && k < 64) begin
      @(negedge Clock);
      k++;
    end
    if (!InReady) check("accept_timeout", k, 0);
    else begin
      @(posedge Clock);
      #1;
    end
    InValid = 1'b0;
  endtask

  task automatic send_sub(input logic [31:0] a, input logic [31:0] b,
                          input logic bi);
    logic [32:0] r;
    r = sub_model(a, b, bi);
    send(a, b, bi, r[31:0], r[32]);
  endtask

  // Feed an adder's {CO,S}; the subtractor must give back {CO,A}.
  task automatic send_rt(input logic [31:0] a, input logic [31:0] b,
                         input logic ci);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + 33'(ci);
    send(s[31:0], b, ci, a, s[32]);
  endtask

  task automatic wait_ret(input int target);
    int k;
    k = 0;
    while (ret_cnt < target && k < 500) begin
      @(posedge Clock);
      #1;
      k++;
    end
    check("drain", ret_cnt, target);
  endtask

  task automatic directed(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic bi,
                          input logic [32:0] lit);
    int base;
    base = ret_cnt;
    send_sub(a, b, bi);
    wait_ret(base + 1);
    check(nm, out_last, lit);
  endtask

  initial begin
    #1;
    check("rst_outvalid", OutValid, 1'b0);
    check("rst_d", D, 32'h0);
    check("rst_bo", BO, 1'b0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("rst_inready", InReady, 1'b1);
    @(posedge Clock);
    #1;

    // Latency and basic result
    begin
      logic [32:0] r;
      r = sub_model(32'h5, 32'h3, 1'b0);
      A = 32'h5;
      B = 32'h3;
      BI = 1'b0;
      exp_d = r[31:0];
      exp_bo = r[32];
      InValid = 1'b1;
    end
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
      if (n == 1) InValid = 1'b0;
    end while (!OutValid && n < 20);
    check("latency", n, 4);
    check("basic_d", D, 32'h2);
    check("basic_bo", BO, 1'b0);
    @(posedge Clock);
    #1;

    directed("wrap_0_minus_1", 32'h0, 32'h1, 1'b0, 33'h1_FFFF_FFFF);
    directed("wrap_eq_bi", 32'h8000_0000, 32'h8000_0000, 1'b1,
             33'h1_FFFF_FFFF);
    directed("cross_slice", 32'h0100_0000, 32'h1, 1'b0, 33'h0_00FF_FFFF);
    directed("equal_zero", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 33'h0);
    directed("max_bi", 32'hFFFF_FFFF, 32'h0, 1'b1, 33'h0_FFFF_FFFE);

    // Mid-stream reset with three operands in flight
    OutReady = 1'b0;
    base_ret = ret_cnt;
    send_sub(32'h1111_1111, 32'h1, 1'b0);
    send_sub(32'h2222_2222, 32'h2, 1'b0);
    send_sub(32'h3333_3333, 32'h3, 1'b1);
    n = 0;
    while (!OutValid && n < 20) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check("stall_fill", OutValid, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_outvalid", OutValid, 1'b0);
    check("rst_mid_d", D, 32'h0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    OutReady = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge Clock);
      if (OutValid) seen++;
    end
    check("rst_no_ghost", seen, 0);
    check("rst_no_ret", ret_cnt, base_ret);
    @(posedge Clock);
    #1;

    // Backpressure: 8 back-to-back with the consumer stalled for 6 cycles
    OutReady = 1'b0;
    base_acc = acc_cnt;
    base_ret = ret_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_sub(32'h1000 * i + 32'h77, 32'h33 * i, 1'(i & 1));
      end
      begin
        repeat (6) @(posedge Clock);
        #1;
        check("bp_accepts", acc_cnt - base_acc, 4);
        check("bp_inready", InReady, 1'b0);
        OutReady = 1'b1;
      end
    join
    wait_ret(base_ret + 8);

    // Random adder round-trip with random consumer stalls
    base_ret = ret_cnt;
    done = 1'b0;
    fork
      begin
        logic [31:0] ra, rb;
        logic        rc;
        for (int i = 0; i < 256; i++) begin
          ra = $urandom;
          rb = $urandom;
          rc = 1'($urandom_range(0, 1));
          if (i % 32 == 0) rb = ~ra;
          if (i % 32 == 1) ra = 32'h0;
          send_rt(ra, rb, rc);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge Clock);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!(done && ret_cnt >= base_ret + 256) && k < 20000) begin
          @(posedge Clock);
          #1;
          OutReady = ($urandom_range(0, 3) != 0);
          k++;
        end
        OutReady = 1'b1;
      end
    join
    check("rt_count", ret_cnt - base_ret, 256);
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
